nn_train_sequencer: RTL

Parametrised training/inference sequencer for the fixed-point neural-network datapath. It replaces the hard-wired control unit with a start/done controlled engine that supports:
- any layer count, memory read latency and datapath latency;
- run-time selection of inference or training;
- run-time batch size and iteration count;
- an abort input.

It sits between the coefficient/sample/supervisor memories and the layer node registers. It drives addresses, shift enables, capture strobes and coefficient write-back.

---
 rtl/nn_train_sequencer_if.sv | 26 ++
 rtl/nn_train_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/nn_train_sequencer_if.sv
// nn_train_sequencer_if: control bus between the training sequencer and the NN datapath/memories.
interface nn_train_sequencer_if #(
    parameter int A = 16,
    parameter int ND = 4,
    parameter int S = 4
);
    logic start, abort, train;
    logic [15:0] batch, max_it;
    logic busy, done;
    logic [2:0] state;
    logic [15:0] iter;
    logic [A-1:0] nd_addr, x_addr, y_addr, t_addr;
    logic nd_we, dtb, in_we, y_we, bp_we;
    logic [S-1:0] save_sel;
    logic [ND-1:0] c_we;
    modport master (
        input  start, abort, train, batch, max_it,
        output busy, done, state, iter, nd_addr, nd_we, dtb, save_sel, c_we,
               x_addr, in_we, y_addr, y_we, t_addr, bp_we
    );
    modport slave (
        output start, abort, train, batch, max_it,
        input  busy, done, state, iter, nd_addr, nd_we, dtb, save_sel, c_we,
               x_addr, in_we, y_addr, y_we, t_addr, bp_we
    );
endinterface

// File: rtl/nn_train_sequencer.sv
// nn_train_sequencer: start/done driven coefficient load, forward/train and save sequencer for the
// fixed-point NN datapath; every output is registered from the next-state values.
module nn_train_sequencer #(
    parameter int LTOT = 3,
    parameter logic [32*LTOT-1:0] LR = {32'd1, 32'd3, 32'd2},
    parameter int ND = 4,
    parameter int WT = 9,
    parameter int A = 16,
    parameter int RD_LAT = 1,
    parameter int DP = 2,
    parameter int T0 = 12001
) (
    input  logic clk,
    input  logic rst,
    nn_train_sequencer_if.master bus
);
    localparam int W = WT + ND;
    localparam int S = $clog2(W);
    localparam int SX = int'(LR[31:0]);
    localparam int P = SX + RD_LAT + DP;
    localparam int LD = W + RD_LAT;
    typedef enum logic [2:0] {IDLE, LOAD, FWD, TRAIN, SAVE, DONE} state_e;
    state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d, base_d;
    logic [15:0] s_q, s_d, iter_q, iter_d, batch_q, batch_d, max_q, max_d;
    logic train_q, train_d, smp, sv;
    // Node words are contiguous per node: bias then one weight per node of the previous layer.
    function automatic logic [ND-1:0] owner(input int k);
        int base, n, fan;
        base = 0;
        n = 0;
        owner = '0;
        for (int l = 1; l < LTOT; l++) begin
            fan = int'(LR[32*(l-1) +: 32]) + 1;
            for (int j = 0; j < int'(LR[32*l +: 32]); j++) begin
                if (k >= base && k < base + fan) owner = ND'(1) << (ND - 1 - n);
                base += fan;
                n++;
            end
        end
    endfunction
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 32'd1;
        s_d = s_q;
        iter_d = iter_q;
        batch_d = batch_q;
        max_d = max_q;
        train_d = train_q;
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (bus.start) begin
                        train_d = bus.train;
                        batch_d = bus.batch;
                        max_d = bus.max_it;
                        iter_d = '0;
                        s_d = '0;
                        state_d = (bus.batch == 16'd0 || (bus.train && bus.max_it == 16'd0)) ? DONE : LOAD;
                    end
                end
                LOAD: if (cnt_q == 32'(LD - 1)) begin
                    state_d = train_q ? TRAIN : FWD;
                    cnt_d = '0;
                    s_d = '0;
                end
                FWD, TRAIN: if (cnt_q == 32'(P - 1)) begin
                    cnt_d = '0;
                    s_d = s_q + 16'd1;
                    if (s_q == batch_q - 16'd1) state_d = (state_q == TRAIN) ? SAVE : DONE;
                end
                SAVE: if (cnt_q == 32'(W - 1)) begin
                    cnt_d = '0;
                    iter_d = iter_q + 16'd1;
                    state_d = (iter_q + 16'd1 == max_q) ? DONE : LOAD;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end
    assign smp = state_d == FWD || state_d == TRAIN;
    assign sv = state_d == SAVE;
    assign base_d = 32'(iter_d) * 32'(batch_d) + 32'(s_d);
    assign bus.state = state_q;
    assign bus.iter = iter_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            s_q <= '0;
            iter_q <= '0;
            batch_q <= '0;
            max_q <= '0;
            train_q <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.nd_addr <= '0;
            bus.nd_we <= 1'b0;
            bus.dtb <= 1'b0;
            bus.save_sel <= '0;
            bus.c_we <= '0;
            bus.x_addr <= '0;
            bus.in_we <= 1'b0;
            bus.y_addr <= '0;
            bus.y_we <= 1'b0;
            bus.t_addr <= A'(T0);
            bus.bp_we <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            s_q <= s_d;
            iter_q <= iter_d;
            batch_q <= batch_d;
            max_q <= max_d;
            train_q <= train_d;
            bus.busy <= state_d != IDLE;
            bus.done <= state_d == DONE;
            bus.nd_addr <= ((state_d == LOAD && cnt_d < W) || sv) ? A'(cnt_d) : '0;
            bus.nd_we <= sv;
            bus.dtb <= sv;
            bus.save_sel <= sv ? S'(cnt_d) : '0;
            bus.c_we <= (state_d == LOAD && cnt_d >= RD_LAT) ? owner(int'(cnt_d) - RD_LAT) : '0;
            bus.x_addr <= (smp && cnt_d < SX) ? A'(base_d * SX + cnt_d) : '0;
            bus.in_we <= smp && cnt_d >= RD_LAT && cnt_d < RD_LAT + SX;
            bus.y_addr <= smp ? A'(base_d) : '0;
            bus.y_we <= state_d == FWD && cnt_d == 32'(P - 1);
            bus.t_addr <= A'(smp ? base_d + T0 : T0);
            bus.bp_we <= state_d == TRAIN && cnt_d == 32'(P - 1);
        end
    end
endmodule
